// File: rtl/freq_meter_pkg.sv
// Shared encodings for the frequency meter: gate selections, their Hz
// scale factors and the measurement FSM states.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        GATE_1S    = 2'b00,
        GATE_100MS = 2'b01,
        GATE_10MS  = 2'b10,
        GATE_1MS   = 2'b11
    } gate_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GATE  = 2'b01,
        ST_LATCH = 2'b10
    } state_e;

    // Multiplier that turns an edge count over the gate into Hz.
    localparam int unsigned SCALE_1S    = 1;
    localparam int unsigned SCALE_100MS = 10;
    localparam int unsigned SCALE_10MS  = 100;
    localparam int unsigned SCALE_1MS   = 1000;
    localparam int unsigned SCALE_W     = 10;

    function automatic logic [SCALE_W-1:0] gate_scale(input logic [1:0] sel);
        logic [SCALE_W-1:0] scale;
        case (sel)
            GATE_1S:    scale = SCALE_W'(SCALE_1S);
            GATE_100MS: scale = SCALE_W'(SCALE_100MS);
            GATE_10MS:  scale = SCALE_W'(SCALE_10MS);
            default:    scale = SCALE_W'(SCALE_1MS);
        endcase
        return scale;
    endfunction

endpackage

// File: rtl/freq_meter_edge_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// A transition on async_i produces a one-cycle rise_o pulse three clocks later.
module edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;

    // Synchronize the input, remember its previous level and flag 0->1 steps.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous input over a
// 1 s / 100 ms / 10 ms / 1 ms window of CLK and reports count and Hz.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned CNT_W  = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             SIG,
    input  logic [1:0]       GATE_SEL,
    input  logic             START,
    input  logic             CONTINUOUS,
    output logic             BUSY,
    output logic             VALID,
    output logic [CNT_W-1:0] COUNT,
    output logic [CNT_W+9:0] FREQ_HZ,
    output logic             OVERFLOW,
    output logic [1:0]       GATE_USED
);

    localparam int unsigned FREQ_W = CNT_W + 10;
    localparam int unsigned GCNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    // Gate length minus one, loaded on gate entry so the gate lasts N cycles.
    function automatic logic [GCNT_W-1:0] gate_len_m1(input logic [1:0] sel);
        logic [GCNT_W-1:0] len;
        case (sel)
            GATE_1S:    len = GCNT_W'(CLK_HZ - 1);
            GATE_100MS: len = GCNT_W'(CLK_HZ / 10 - 1);
            GATE_10MS:  len = GCNT_W'(CLK_HZ / 100 - 1);
            default:    len = GCNT_W'(CLK_HZ / 1000 - 1);
        endcase
        return len;
    endfunction

    // Full-width count-to-Hz conversion; the 10 extra bits hold a x1000 scale.
    function automatic logic [FREQ_W-1:0] scale_freq(input logic [CNT_W-1:0] cnt,
                                                     input logic [1:0]       sel);
        logic [FREQ_W-1:0] ext;
        ext = FREQ_W'(cnt);
        return ext * FREQ_W'(gate_scale(sel));
    endfunction

    logic              edge_pulse;
    state_e            state_q, state_d;
    logic              gate_load;
    logic [GCNT_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              ovf_run_q, ovf_run_d;
    logic [1:0]        sel_q, sel_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        used_q, used_d;

    edge_sync u_sig_sync (
        .clk_i   (CLK),
        .rst_ni  (RESET_N),
        .async_i (SIG),
        .rise_o  (edge_pulse)
    );

    // Measurement sequencing: idle, count during the gate, latch for one cycle.
    always_comb begin
        state_d   = state_q;
        gate_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START || CONTINUOUS) begin
                    state_d   = ST_GATE;
                    gate_load = 1'b1;
                end
            end
            ST_GATE: begin
                if (gate_cnt_q == '0) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (CONTINUOUS) begin
                    state_d   = ST_GATE;
                    gate_load = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate timer and edge counter; edges outside GATE are dropped. The
    // overflow flag marks an edge lost because the counter was already full.
    always_comb begin
        gate_cnt_d = gate_cnt_q;
        edge_cnt_d = edge_cnt_q;
        ovf_run_d  = ovf_run_q;
        sel_d      = sel_q;
        if (gate_load) begin
            gate_cnt_d = gate_len_m1(GATE_SEL);
            edge_cnt_d = '0;
            ovf_run_d  = 1'b0;
            sel_d      = GATE_SEL;
        end else if (state_q == ST_GATE) begin
            if (gate_cnt_q != '0) begin
                gate_cnt_d = gate_cnt_q - GCNT_W'(1);
            end
            if (edge_pulse) begin
                if (&edge_cnt_q) begin
                    ovf_run_d = 1'b1;
                end else begin
                    edge_cnt_d = edge_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Result capture in the LATCH cycle; results hold until the next LATCH.
    always_comb begin
        valid_d = 1'b0;
        count_d = count_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        used_d  = used_q;
        if (state_q == ST_LATCH) begin
            valid_d = 1'b1;
            count_d = edge_cnt_q;
            freq_d  = scale_freq(edge_cnt_q, sel_q);
            ovf_d   = ovf_run_q;
            used_d  = sel_q;
        end
    end

    // State and counters; reset aborts any measurement in flight.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            ovf_run_q  <= 1'b0;
            sel_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_run_q  <= ovf_run_d;
            sel_q      <= sel_d;
        end
    end

    // Published result registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            valid_q <= 1'b0;
            count_q <= '0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            used_q  <= 2'b00;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            used_q  <= used_d;
        end
    end

    assign BUSY      = (state_q != ST_IDLE);
    assign VALID     = valid_q;
    assign COUNT     = count_q;
    assign FREQ_HZ   = freq_q;
    assign OVERFLOW  = ovf_q;
    assign GATE_USED = used_q;

endmodule
